// File: rtl/fgmt_pkg.sv
// Shared types and defaults for the fine-grained multithreaded fetch path.
// Build option: FGMT_SPEC_PREFETCH_EN enables speculative next-line prefetch requests.
package fgmt_pkg;

  localparam int unsigned TID_BITS     = 2;
  localparam int unsigned NTHREADS_DEF = 2 ** TID_BITS;
  localparam int unsigned TIMEOUT_DEF  = 64;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = 128;
  localparam int unsigned OFF_W      = 4;
  localparam int unsigned LINE_TAG_W = WORD_W - OFF_W;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    REQ_REFILL = 2'd0,
    REQ_BRANCH = 2'd1,
    REQ_SPEC   = 2'd2
  } req_kind_t;

endpackage

// File: rtl/l1_refill_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after (last+1) mod N.
module l1_refill_arbiter_rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [IW-1:0] o_grant_c,
  output logic          o_any_c
);

  int unsigned w_idx;

  always_comb begin
    o_grant_c = '0;
    o_any_c   = 1'b0;
    w_idx     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_idx = (32'(i_last) + i) % N;
      if (!o_any_c && i_req[IW'(w_idx)]) begin
        o_any_c   = 1'b1;
        o_grant_c = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/l1_refill_arbiter.sv
// Shares the single L2 request port among per-thread L1 I-caches, one request in flight.
// Build option: FGMT_SPEC_PREFETCH_EN lets speculative next-line prefetches compete for the port.
module l1_refill_arbiter
  import fgmt_pkg::*;
#(
  parameter int unsigned NTHREADS = NTHREADS_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NTHREADS-1:0]  l1_req_refill,
  input  logic [NTHREADS-1:0]  l1_br_req,
  input  logic [NTHREADS-1:0]  l1_req_spec,
  input  word_t [NTHREADS-1:0] l1_addr,
  output logic                 l2_req_valid,
  input  logic                 l2_req_ready,
  output word_t                l2_req_addr,
  output logic [TID_BITS-1:0]  l2_req_tid,
  output req_kind_t            l2_req_kind,
  input  logic                 l2_rsp_valid,
  input  logic [TID_BITS-1:0]  l2_rsp_tid,
  input  word_t                l2_rsp_addr,
  input  line_t                l2_rsp_line,
  output logic                 l2_valid_rsp,
  output logic [TID_BITS-1:0]  l2_tid,
  output word_t                l2addr,
  output line_t                l2_line,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]          r_state, w_state_nxt;
  logic [TID_BITS-1:0] r_last, w_last_nxt;
  logic [TID_BITS-1:0] r_tid, w_tid_nxt;
  req_kind_t           r_kind, w_kind_nxt;
  word_t               r_addr, w_addr_nxt;
  logic                r_req_valid, w_req_valid_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [TID_BITS-1:0] r_rsp_tid, w_rsp_tid_nxt;
  word_t               r_rsp_addr, w_rsp_addr_nxt;
  line_t               r_rsp_line, w_rsp_line_nxt;
  logic                r_timeout, w_timeout_nxt;

  logic [NTHREADS-1:0] w_pick_vec;
  req_kind_t           w_kind_sel;
  logic [TID_BITS-1:0] w_grant;
  logic                w_any;
  word_t               w_sel_addr;
  word_t               w_addr_sel;
  logic                w_unused_off;

  // Highest non-empty class wins; round-robin happens only inside that class.
  always_comb begin
    w_pick_vec = '0;
    w_kind_sel = REQ_REFILL;
    if (|l1_req_refill) begin
      w_pick_vec = l1_req_refill;
    end else if (|l1_br_req) begin
      w_pick_vec = l1_br_req;
      w_kind_sel = REQ_BRANCH;
    end
`ifdef FGMT_SPEC_PREFETCH_EN
    else if (|l1_req_spec) begin
      w_pick_vec = l1_req_spec;
      w_kind_sel = REQ_SPEC;
    end
`endif
  end

`ifndef FGMT_SPEC_PREFETCH_EN
  logic w_unused_spec;
  assign w_unused_spec = ^l1_req_spec;
`endif

  l1_refill_arbiter_rr_picker #(
    .N  (NTHREADS),
    .IW (TID_BITS)
  ) u_picker (
    .i_req     (w_pick_vec),
    .i_last    (r_last),
    .o_grant_c (w_grant),
    .o_any_c   (w_any)
  );

  // Line-align the winner's address; prefetches target the following line.
  always_comb begin
    w_sel_addr   = l1_addr[w_grant];
    w_unused_off = ^w_sel_addr[OFF_W-1:0];
`ifdef FGMT_SPEC_PREFETCH_EN
    if (w_kind_sel == REQ_SPEC) begin
      w_addr_sel = {w_sel_addr[WORD_W-1:OFF_W] + LINE_TAG_W'(1), OFF_W'(0)};
    end else begin
      w_addr_sel = {w_sel_addr[WORD_W-1:OFF_W], OFF_W'(0)};
    end
`else
    w_addr_sel = {w_sel_addr[WORD_W-1:OFF_W], OFF_W'(0)};
`endif
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_tid_nxt       = r_tid;
    w_kind_nxt      = r_kind;
    w_addr_nxt      = r_addr;
    w_req_valid_nxt = r_req_valid;
    w_cnt_nxt       = r_cnt;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_tid_nxt   = r_rsp_tid;
    w_rsp_addr_nxt  = r_rsp_addr;
    w_rsp_line_nxt  = r_rsp_line;
    w_timeout_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt     = ST_REQ;
          w_req_valid_nxt = 1'b1;
          w_tid_nxt       = w_grant;
          w_kind_nxt      = w_kind_sel;
          w_addr_nxt      = w_addr_sel;
          w_last_nxt      = w_grant;
        end
      end
      ST_REQ: begin
        if (l2_req_ready) begin
          w_state_nxt     = ST_WAIT;
          w_req_valid_nxt = 1'b0;
          w_cnt_nxt       = '0;
        end
      end
      ST_WAIT: begin
        // A matching response in the last allowed cycle still beats the timeout.
        if (l2_rsp_valid && (l2_rsp_tid == r_tid)) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_tid_nxt   = l2_rsp_tid;
          w_rsp_addr_nxt  = l2_rsp_addr;
          w_rsp_line_nxt  = l2_rsp_line;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt   = ST_IDLE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_req_valid_nxt = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_last      <= TID_BITS'(NTHREADS - 1);
      r_tid       <= '0;
      r_kind      <= REQ_REFILL;
      r_addr      <= '0;
      r_req_valid <= 1'b0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_tid   <= '0;
      r_rsp_addr  <= '0;
      r_rsp_line  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_tid       <= w_tid_nxt;
      r_kind      <= w_kind_nxt;
      r_addr      <= w_addr_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= w_busy_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_tid   <= w_rsp_tid_nxt;
      r_rsp_addr  <= w_rsp_addr_nxt;
      r_rsp_line  <= w_rsp_line_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign l2_req_valid = r_req_valid;
  assign l2_req_addr  = r_addr;
  assign l2_req_tid   = r_tid;
  assign l2_req_kind  = r_kind;
  assign l2_valid_rsp = r_rsp_valid;
  assign l2_tid       = r_rsp_tid;
  assign l2addr       = r_rsp_addr;
  assign l2_line      = r_rsp_line;
  assign busy         = r_busy;
  assign timeout_err  = r_timeout;

endmodule

// File: tb/tb_l1_refill_arbiter.sv
// Randomized bench for l1_refill_arbiter against a transaction-level arbitration model.
// Honours FGMT_SPEC_PREFETCH_EN the same way the design does.
module tb_l1_refill_arbiter;
  import fgmt_pkg::*;

  localparam int unsigned N  = NTHREADS_DEF;
  localparam int unsigned TO = TIMEOUT_DEF;
  localparam int unsigned TW = TID_BITS;
`ifdef FGMT_SPEC_PREFETCH_EN
  localparam bit SPEC_EN = 1'b1;
`else
  localparam bit SPEC_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  l1_req_refill = '0;
  logic [N-1:0]  l1_br_req = '0;
  logic [N-1:0]  l1_req_spec = '0;
  word_t [N-1:0] l1_addr = '0;
  logic          l2_req_valid;
  logic          l2_req_ready = 1'b0;
  word_t         l2_req_addr;
  logic [TW-1:0] l2_req_tid;
  req_kind_t     l2_req_kind;
  logic          l2_rsp_valid = 1'b0;
  logic [TW-1:0] l2_rsp_tid = '0;
  word_t         l2_rsp_addr = '0;
  line_t         l2_rsp_line = '0;
  logic          l2_valid_rsp;
  logic [TW-1:0] l2_tid;
  word_t         l2addr;
  line_t         l2_line;
  logic          busy;
  logic          timeout_err;

  int n_checks = 0;
  int n_fails  = 0;
  int m_last;

  l1_refill_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .l1_req_refill (l1_req_refill),
    .l1_br_req     (l1_br_req),
    .l1_req_spec   (l1_req_spec),
    .l1_addr       (l1_addr),
    .l2_req_valid  (l2_req_valid),
    .l2_req_ready  (l2_req_ready),
    .l2_req_addr   (l2_req_addr),
    .l2_req_tid    (l2_req_tid),
    .l2_req_kind   (l2_req_kind),
    .l2_rsp_valid  (l2_rsp_valid),
    .l2_rsp_tid    (l2_rsp_tid),
    .l2_rsp_addr   (l2_rsp_addr),
    .l2_rsp_line   (l2_rsp_line),
    .l2_valid_rsp  (l2_valid_rsp),
    .l2_tid        (l2_tid),
    .l2addr        (l2addr),
    .l2_line       (l2_line),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: first requester after the last grant, wrapping around the thread ring.
  function automatic int pick_rr(input logic [N-1:0] v, input int last);
    int idx;
    for (int k = 1; k <= int'(N); k++) begin
      idx = (last + k) % int'(N);
      if (v[TW'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_req_valid"}, 128'(l2_req_valid), 128'(0));
    check_eq({pfx, "_req_addr"},  128'(l2_req_addr),  128'(0));
    check_eq({pfx, "_req_tid"},   128'(l2_req_tid),   128'(0));
    check_eq({pfx, "_req_kind"},  128'(l2_req_kind),  128'(0));
    check_eq({pfx, "_valid_rsp"}, 128'(l2_valid_rsp), 128'(0));
    check_eq({pfx, "_l2_tid"},    128'(l2_tid),       128'(0));
    check_eq({pfx, "_l2addr"},    128'(l2addr),       128'(0));
    check_eq({pfx, "_l2_line"},   128'(l2_line),      128'(0));
    check_eq({pfx, "_busy"},      128'(busy),         128'(0));
    check_eq({pfx, "_timeout"},   128'(timeout_err),  128'(0));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    l1_req_refill = '0; l1_br_req = '0; l1_req_spec = '0;
    l2_req_ready = 1'b0; l2_rsp_valid = 1'b0;
    #1;
    check_all_zero("rst");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    m_last = int'(N) - 1;
  endtask

  // One whole transaction, entered and left at a negedge with the DUT idle.
  // delay: WAIT cycle carrying the matching response; 0 or >TO means let it time out.
  task automatic run_txn(input logic [N-1:0] rf, input logic [N-1:0] br, input logic [N-1:0] sp,
                         input int stall, input int delay, input bit strays);
    logic [N-1:0] v;
    int           tid;
    req_kind_t    kind;
    word_t        a;
    word_t        ra;
    line_t        rl;
    v = '0;
    kind = REQ_REFILL;
    if (rf != '0) v = rf;
    else if (br != '0) begin v = br; kind = REQ_BRANCH; end
    else if (SPEC_EN && sp != '0) begin v = sp; kind = REQ_SPEC; end
    tid = pick_rr(v, m_last);
    l1_req_refill = rf; l1_br_req = br; l1_req_spec = sp;
    @(posedge clock); @(negedge clock);
    l1_req_refill = '0; l1_br_req = '0; l1_req_spec = '0;
    if (tid < 0) begin
      check_eq("noreq_valid", 128'(l2_req_valid), 128'(0));
      check_eq("noreq_busy",  128'(busy),         128'(0));
      return;
    end
    a = l1_addr[TW'(tid)] & 32'hFFFF_FFF0;
    if (kind == REQ_SPEC) a = a + 32'h10;
    m_last = tid;
    check_eq("grant_valid", 128'(l2_req_valid), 128'(1));
    check_eq("grant_tid",   128'(l2_req_tid),   128'(tid));
    check_eq("grant_kind",  128'(l2_req_kind),  128'(kind));
    check_eq("grant_addr",  128'(l2_req_addr),  128'(a));
    check_eq("grant_busy",  128'(busy),         128'(1));
    check_eq("rsp_pulse_end", 128'(l2_valid_rsp), 128'(0));
    check_eq("grant_timeout", 128'(timeout_err), 128'(0));
    repeat (stall) begin
      l2_req_ready = 1'b0;
      @(posedge clock); @(negedge clock);
      check_eq("stall_valid", 128'(l2_req_valid), 128'(1));
      check_eq("stall_tid",   128'(l2_req_tid),   128'(tid));
      check_eq("stall_kind",  128'(l2_req_kind),  128'(kind));
      check_eq("stall_addr",  128'(l2_req_addr),  128'(a));
    end
    l2_req_ready = 1'b1;
    l2_rsp_valid = 1'b1;
    l2_rsp_tid = TW'(tid);
    @(posedge clock); @(negedge clock);
    l2_req_ready = 1'b0;
    l2_rsp_valid = 1'b0;
    check_eq("hs_valid",     128'(l2_req_valid), 128'(0));
    check_eq("hs_early_rsp", 128'(l2_valid_rsp), 128'(0));
    check_eq("hs_busy",      128'(busy),         128'(1));
    for (int k = 1; k <= int'(TO); k++) begin
      ra = $urandom();
      rl = {$urandom(), $urandom(), $urandom(), $urandom()};
      l2_rsp_addr = ra;
      l2_rsp_line = rl;
      if (k == delay) begin
        l2_rsp_valid = 1'b1;
        l2_rsp_tid = TW'(tid);
      end else if (strays && $urandom_range(0, 1) == 1) begin
        l2_rsp_valid = 1'b1;
        l2_rsp_tid = TW'((tid + int'($urandom_range(1, N - 1))) % int'(N));
      end else begin
        l2_rsp_valid = 1'b0;
        l2_rsp_tid = TW'($urandom());
      end
      @(posedge clock); @(negedge clock);
      l2_rsp_valid = 1'b0;
      if (k == delay) begin
        check_eq("rsp_valid",   128'(l2_valid_rsp), 128'(1));
        check_eq("rsp_tid",     128'(l2_tid),       128'(tid));
        check_eq("rsp_addr",    128'(l2addr),       128'(ra));
        check_eq("rsp_line",    128'(l2_line),      128'(rl));
        check_eq("rsp_busy",    128'(busy),         128'(0));
        check_eq("rsp_timeout", 128'(timeout_err),  128'(0));
        break;
      end else if (k == int'(TO)) begin
        check_eq("to_pulse",     128'(timeout_err),  128'(1));
        check_eq("to_busy",      128'(busy),         128'(0));
        check_eq("to_valid_rsp", 128'(l2_valid_rsp), 128'(0));
      end else begin
        check_eq("wait_valid_rsp", 128'(l2_valid_rsp), 128'(0));
        check_eq("wait_timeout",   128'(timeout_err),  128'(0));
        check_eq("wait_busy",      128'(busy),         128'(1));
      end
    end
  endtask

  initial begin
    int r;
    int dly;
    do_reset();

    // Single refill from thread 0.
    l1_addr[0] = 32'h0000_1234;
    run_txn(N'(1), '0, '0, 0, 3, 1'b0);

    // Class priority with all three classes pending at once.
    for (int t = 0; t < int'(N); t++) l1_addr[TW'(t)] = $urandom();
    l1_addr[0] = 32'h0000_5678;
    run_txn(N'(4), N'(2), N'(1), 0, 2, 1'b0);
    run_txn('0, N'(2), N'(1), 0, 2, 1'b0);
    run_txn('0, '0, N'(1), 0, 2, 1'b0);

    // Every thread refilling: rotation 0,1,2,3,0 from reset.
    do_reset();
    for (int i = 0; i < 5; i++) run_txn({N{1'b1}}, '0, '0, 0, 1, 1'b0);

    // Ready held low, then thread 1 abandoned after stray responses.
    run_txn(N'(2), '0, '0, 5, 4, 1'b0);
    run_txn(N'(2), '0, '0, 0, 0, 1'b1);

    // Prefetch from the top line wraps to address zero.
    l1_addr[0] = 32'hFFFF_FFF8;
    run_txn('0, '0, N'(1), 0, 1, 1'b0);

    // Reset while waiting on a response aborts it.
    l1_addr[1] = 32'hCAFE_0044;
    l1_req_refill = N'(2);
    @(posedge clock); @(negedge clock);
    l1_req_refill = '0;
    check_eq("mo_valid", 128'(l2_req_valid), 128'(1));
    l2_req_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    l2_req_ready = 1'b0;
    check_eq("mo_busy", 128'(busy), 128'(1));
    reset = 1'b0;
    l2_rsp_valid = 1'b1;
    l2_rsp_tid = TW'(1);
    #1;
    check_eq("mo_rst_busy",  128'(busy),         128'(0));
    check_eq("mo_rst_valid", 128'(l2_req_valid), 128'(0));
    check_eq("mo_rst_rsp",   128'(l2_valid_rsp), 128'(0));
    @(negedge clock);
    reset = 1'b1;
    m_last = int'(N) - 1;
    @(posedge clock); @(negedge clock);
    check_eq("mo_post_rsp",  128'(l2_valid_rsp), 128'(0));
    check_eq("mo_post_busy", 128'(busy),         128'(0));
    l2_rsp_valid = 1'b0;

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      for (int t = 0; t < int'(N); t++) l1_addr[TW'(t)] = $urandom();
      r = int'($urandom_range(0, 9));
      dly = (r == 0) ? 0 : (r == 1) ? int'(TO) : int'($urandom_range(1, 8));
      run_txn(($urandom_range(0, 2) == 0) ? N'($urandom()) : '0,
              ($urandom_range(0, 1) == 0) ? N'($urandom()) : '0,
              N'($urandom()),
              int'($urandom_range(0, 3)), dly, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
